pci_bus_arbiter: RTL and testbench
==================================

// Module: pci_bus_arbiter
// PURPOSE
// Central PCI bus arbiter. Shares one PCI bus between NUM_MASTERS initiators over per-master
// REQ_/GNT_ pairs, using round-robin priority. Monitors FRAME_/IRDY_ to track bus idle/busy.
// Parks the bus on a default master when nobody requests.
// Revokes a grant that the master does not use within a timeout.
// Sits beside the bus protocol checker; its gnt_ outputs drive the initiators' GNT_ inputs.
// PARAMETERS
// NUM_MASTERS  4   number of initiators (2..8)
// PARK_MASTER  0   index granted when no req_ is asserted
// GNT_TIMEOUT  16  idle-bus clocks a requesting grantee may hold gnt_ without starting FRAME_
// PORTS
// clk        in   1            bus clock, all logic on posedge
// reset      in   1            synchronous, active-high
// req_       in   NUM_MASTERS  per-master request, active low
// FRAME_     in   1            PCI FRAME_, active low
// IRDY_      in   1            PCI IRDY_, active low
// gnt_       out  NUM_MASTERS  per-master grant, active low; at most one bit low
// owner      out  $clog2(NUM_MASTERS)  index of current/last grantee
// bus_busy   out  1            registered: 1 while a transaction is in progress
// BEHAVIOUR
// - bus_idle = FRAME_ & IRDY_ (sampled at posedge). Start of transaction = FRAME_ low while previous sample high.
// - Registered outputs. Reset values: gnt_ = all 1, owner = PARK_MASTER, bus_busy = 0.
// - After reset: state GAP, rr_ptr = PARK_MASTER, timeout counter = 0.
// - States:
//   GAP: all gnt_ high for exactly one clock.
//     Arbitrate on req_ sampled this cycle. Search starts at rr_ptr+1 mod NUM_MASTERS; first low req_ wins.
//     No req_ low -> winner = PARK_MASTER (parked).
//     Next clock: gnt_[winner] low, owner = winner -> GRANT.
//   GRANT: gnt_[owner] low.
//     Start of transaction seen -> ACTIVE, bus_busy = 1, rr_ptr = owner.
//     Else, parked owner (req_[owner] high) and any other req_ low -> GAP.
//     Else, requesting owner and bus_idle: count clocks.
//       Count reaches GNT_TIMEOUT -> GAP, rr_ptr = owner (revoked master loses priority).
//       Count resets on entry to GRANT.
//   ACTIVE: gnt_[owner] stays low while req_[owner] low and no other req_ low.
//     Another req_ low -> gnt_[owner] driven high next clock (hidden arbitration; owner finishes current transfer).
//     bus_idle seen -> bus_busy = 0 -> GAP.
// - gnt_ never changes two bits in one clock; a switch between masters always passes through one all-high GAP clock.
// - Grant latency from GAP to gnt_ low: 1 clock.
// - Owner back-to-back: if owner is the only requester in GAP, it is re-granted (no starvation check needed).
// - Simultaneous start of transaction and timeout expiry in the same clock: start wins -> ACTIVE.
// - FRAME_/IRDY_ X/Z: treated as 1 (idle) for state transitions.
// - reset asserted in any state: next clock matches reset values; an in-flight transaction is not tracked.
// - owner holds its value through GAP until the new winner loads.
// TESTING
// 1. Reset, all req_=1 -> after GAP clock gnt_=4'b1110 (park on 0), owner=0, bus_busy=0.
// 2. req_=4'b0101 from parked 0 -> GAP (gnt_=1111) then gnt_=4'b1101 (master 1);
//    after its transaction, next grant goes to master 3.
// 3. Master 2 granted, req_[2]=0, FRAME_ held high 16 clocks -> gnt_ all 1 on clock 17, then next requester granted.
// 4. Master 1 ACTIVE (FRAME_ low), master 3 asserts req_ -> gnt_[1] high next clock, bus_busy stays 1 until FRAME_=IRDY_=1;
//    then GAP, then gnt_=4'b0111.
// 5. All four req_ low continuously with single-cycle transactions -> grants rotate 1,2,3,0,1, each separated by an all-1 clock.
// 6. Assert reset while ACTIVE -> next clock gnt_=1111, owner=0, bus_busy=0; the protocol checker (check1-4) stays clean throughout.

Source files
------------

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with bus parking, hidden arbitration
// and revocation of unused grants.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int PARK_MASTER = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         req_,
  input  logic                           FRAME_,
  input  logic                           IRDY_,
  output logic [NUM_MASTERS-1:0]         gnt_,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           bus_busy
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    GAP,
    GRANT,
    ACTIVE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic                   busy_q, busy_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   frame_q;

  logic                   frame_n, irdy_n;
  logic                   bus_idle, start;
  logic [IW-1:0]          winner;
  logic [NUM_MASTERS-1:0] own_oh, win_oh;
  logic                   own_req, other_req;

  // Undriven or unknown bus lines count as deasserted.
  assign frame_n  = (FRAME_ !== 1'b0);
  assign irdy_n   = (IRDY_ !== 1'b0);
  assign bus_idle = frame_n & irdy_n;
  assign start    = ~frame_n & frame_q;

  assign own_oh    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
  assign win_oh    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
  assign own_req   = ~req_[owner_q];
  assign other_req = |(~req_ & ~own_oh);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    winner = IW'(PARK_MASTER);
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = IW'((int'(rr_q) + i) % NUM_MASTERS);
      if (!found && !req_[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      GAP: begin
        state_d = GRANT;
        gnt_d   = ~win_oh;
        owner_d = winner;
        cnt_d   = '0;
      end
      GRANT: begin
        if (start) begin
          state_d = ACTIVE;
          busy_d  = 1'b1;
          rr_d    = owner_q;
        end else if (!own_req && other_req) begin
          state_d = GAP;
          gnt_d   = '1;
        end else if (own_req && bus_idle) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(GNT_TIMEOUT)) begin
            state_d = GAP;
            gnt_d   = '1;
            rr_d    = owner_q;
          end
        end
      end
      ACTIVE: begin
        if (bus_idle) begin
          state_d = GAP;
          busy_d  = 1'b0;
          gnt_d   = '1;
        end else if (other_req) begin
          gnt_d = '1;
        end
      end
      default: begin
        state_d = GAP;
        gnt_d   = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_n;
    if (reset) begin
      state_q <= GAP;
      gnt_q   <= '1;
      owner_q <= IW'(PARK_MASTER);
      rr_q    <= IW'(PARK_MASTER);
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_     = gnt_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed table, hand sequences for
// timeout/rotation, then random traffic against a reference model.
module tb_pci_bus_arbiter;

  localparam int N    = 4;
  localparam int PARK = 0;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_;
  logic       FRAME_;
  logic       IRDY_;
  logic [3:0] gnt_;
  logic [1:0] owner;
  logic       bus_busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pci_bus_arbiter #(
    .NUM_MASTERS(N),
    .PARK_MASTER(PARK),
    .GNT_TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_    (req_),
    .FRAME_  (FRAME_),
    .IRDY_   (IRDY_),
    .gnt_    (gnt_),
    .owner   (owner),
    .bus_busy(bus_busy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       f;
    logic       i;
    logic [3:0] gnt;
    logic [1:0] own;
    logic       busy;
  } vec_t;

  vec_t tbl[21];

  // reference model state
  int m_hold, m_own, m_last, m_cnt;
  bit m_busy, m_gap, m_xfer, m_prevf;

  task automatic check(input string name, input logic [3:0] eg,
                       input logic [1:0] eo, input logic eb);
    nvec++;
    if (gnt_ !== eg || owner !== eo || bus_busy !== eb) begin
      nerr++;
      $display("FAIL %s @%0t: got gnt_=%b owner=%0d busy=%b, want gnt_=%b owner=%0d busy=%b",
               name, $time, gnt_, owner, bus_busy, eg, eo, eb);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q,
                      input logic f, input logic i);
    reset  = r;
    req_   = q;
    FRAME_ = f;
    IRDY_  = i;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gmask(input int k);
    logic [3:0] m;
    m = 4'b1111;
    if (k >= 0) m[k] = 1'b0;
    return m;
  endfunction

  // One bus clock of the arbitration rules, expressed on a holder index.
  task automatic model_step(input bit r, input logic [3:0] q,
                            input bit f, input bit i);
    bit idle, start, others;
    int w;
    if (r) begin
      m_hold = -1; m_own = PARK; m_last = PARK; m_cnt = 0;
      m_busy = 0; m_gap = 1; m_xfer = 0;
    end else begin
      idle  = f && i;
      start = !f && m_prevf;
      others = 0;
      for (int j = 0; j < N; j++)
        if (j != m_own && !q[j]) others = 1;
      if (m_gap) begin
        w = PARK;
        for (int k = N; k >= 1; k--)
          if (!q[(m_last + k) % N]) w = (m_last + k) % N;
        m_hold = w; m_own = w; m_gap = 0; m_cnt = 0;
      end else if (m_xfer) begin
        if (idle) begin
          m_xfer = 0; m_busy = 0; m_hold = -1; m_gap = 1;
        end else if (others) begin
          m_hold = -1;
        end
      end else begin
        if (start) begin
          m_xfer = 1; m_busy = 1; m_last = m_own;
        end else if (q[m_own] && others) begin
          m_hold = -1; m_gap = 1;
        end else if (!q[m_own] && idle) begin
          m_cnt++;
          if (m_cnt == TMO) begin
            m_hold = -1; m_gap = 1; m_last = m_own;
          end
        end
      end
    end
    m_prevf = f;
  endtask

  initial begin
    logic [3:0] rq;
    logic       quiet, rr, ff, ii;
    int         k;

    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0101, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
    tbl[6]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 4'b0111, 1'b1, 1'b0, 4'b1111, 2'd1, 1'b1};
    tbl[8]  = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0};
    tbl[9]  = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0};
    tbl[10] = '{1'b0, 4'b0111, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b1};
    tbl[11] = '{1'b1, 4'b0111, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0};
    tbl[13] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0};
    tbl[14] = '{1'b0, 4'b1101, 1'b1, 1'b1, 4'b1111, 2'd3, 1'b0};
    tbl[15] = '{1'b0, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0};
    tbl[16] = '{1'b0, 4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
    tbl[17] = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b1};
    tbl[18] = '{1'b0, 4'b0111, 1'b1, 1'b0, 4'b1111, 2'd1, 1'b1};
    tbl[19] = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0};
    tbl[20] = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0};

    for (int t = 0; t < 21; t++) begin
      step(tbl[t].rst, tbl[t].req, tbl[t].f, tbl[t].i);
      check($sformatf("table[%0d]", t), tbl[t].gnt, tbl[t].own, tbl[t].busy);
    end

    // master 3 holds an unused grant until revoked
    for (int c = 1; c < TMO; c++) begin
      step(1'b0, 4'b0111, 1'b1, 1'b1);
      check($sformatf("tmo_hold[%0d]", c), 4'b0111, 2'd3, 1'b0);
    end
    step(1'b0, 4'b0011, 1'b1, 1'b1);
    check("tmo_revoke", 4'b1111, 2'd3, 1'b0);
    step(1'b0, 4'b0011, 1'b1, 1'b1);
    check("tmo_next", 4'b1011, 2'd2, 1'b0);

    // start of transaction on the very clock the timeout would expire
    for (int c = 1; c < TMO; c++) begin
      step(1'b0, 4'b1011, 1'b1, 1'b1);
      check($sformatf("race_hold[%0d]", c), 4'b1011, 2'd2, 1'b0);
    end
    step(1'b0, 4'b1011, 1'b0, 1'b1);
    check("race_start", 4'b1011, 2'd2, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 1'b1);
    check("race_end", 4'b1111, 2'd2, 1'b0);
    step(1'b0, 4'b1111, 1'b1, 1'b1);
    check("race_park", 4'b1110, 2'd0, 1'b0);

    // all masters requesting: grants rotate with a gap between each
    step(1'b1, 4'b0000, 1'b1, 1'b1);
    check("rot_reset", 4'b1111, 2'd0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      k = (r + 1) % N;
      step(1'b0, 4'b0000, 1'b1, 1'b1);
      check($sformatf("rot_grant[%0d]", r), gmask(k), 2'(k), 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0);
      check($sformatf("rot_busy[%0d]", r), gmask(k), 2'(k), 1'b1);
      step(1'b0, 4'b0000, 1'b1, 1'b1);
      check($sformatf("rot_gap[%0d]", r), 4'b1111, 2'(k), 1'b0);
    end

    // random traffic against the model
    rq = 4'b1111;
    quiet = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 32 == 0) quiet = 1'($urandom_range(0, 1));
      rr = (c == 0) || ($urandom_range(0, 199) == 0);
      for (int j = 0; j < N; j++)
        if ($urandom_range(0, 7) == 0) rq[j] = ~rq[j];
      if (quiet) begin
        ff = ($urandom_range(0, 39) != 0);
        ii = ($urandom_range(0, 39) != 0);
      end else begin
        ff = ($urandom_range(0, 2) != 0);
        ii = ($urandom_range(0, 2) != 0);
      end
      step(rr, rq, ff, ii);
      model_step(rr, rq, ff, ii);
      check("rand", gmask(m_hold), 2'(m_own), m_busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
